mod_exp_ctrl: RTL

- Left-to-right square-and-multiply controller computing result = in_x^in_e mod in_m.
- Acts as the initiator on the multiplier's start/done/operand interface and drives an external Montgomery multiplier (R = 2^WIDTH) through that handshake.
- Sits above the multiplier in the RSA datapath.
- Caller supplies R mod m and R^2 mod m precomputed.

---
 rtl/mod_exp_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_ctrl
// Description : Left-to-right square-and-multiply controller that computes
//               x^e mod m. It drives an external Montgomery multiplier
//               (R = 2^WIDTH) through a start/done handshake. The caller
//               supplies R mod m and R^2 mod m.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_rr,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    // Index of the final exponent bit; reaching it ends the scan.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SKIP = 3'd1,
        S_TOM  = 3'd2,
        S_SQR  = 3'd3,
        S_MUL  = 3'd4,
        S_NEXT = 3'd5,
        S_FROM = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_wait;      // 0: issue cycle, 1: waiting for mm_done
    logic                   w_wait_nxt;
    logic                   w_capture;   // multiplier result arrives this cycle
    logic                   w_mm_start;
    logic [WIDTH-1:0]       w_mm_a;
    logic [WIDTH-1:0]       w_mm_b;

    logic [WIDTH-1:0]       r_x;
    logic [WIDTH-1:0]       r_xm;
    logic [WIDTH-1:0]       r_rr;
    logic [WIDTH-1:0]       r_m;
    logic [WIDTH-1:0]       r_acc;
    logic [WIDTH-1:0]       r_result;
    logic [EXP_WIDTH-1:0]   r_e;
    logic [CNT_W-1:0]       r_cnt;

    // State register and op-phase flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state decode, multiplier handshake and operand selection.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_capture   = 1'b0;
        w_mm_start  = 1'b0;
        w_mm_a      = '0;
        w_mm_b      = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SKIP;
            end
            S_SKIP: begin
                if (r_e[EXP_WIDTH-1])   w_state_nxt = S_TOM;
                else if (r_cnt == c_last) w_state_nxt = S_FROM;
            end
            S_TOM, S_SQR, S_MUL, S_FROM: begin
                if (!r_wait) begin
                    // Done pulses during the issue cycle are deliberately ignored.
                    w_mm_start = 1'b1;
                    w_wait_nxt = 1'b1;
                end else if (mm_done) begin
                    w_wait_nxt = 1'b0;
                    w_capture  = 1'b1;
                    case (r_state)
                        S_TOM:   w_state_nxt = S_SQR;
                        S_SQR:   w_state_nxt = r_e[EXP_WIDTH-1] ? S_MUL : S_NEXT;
                        S_MUL:   w_state_nxt = S_NEXT;
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_NEXT: begin
                w_state_nxt = (r_cnt == c_last) ? S_FROM : S_SQR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Operands come straight from registers that only change on capture,
        // so they are stable from issue until mm_done.
        case (r_state)
            S_TOM:  begin w_mm_a = r_x;   w_mm_b = r_rr;         end
            S_SQR:  begin w_mm_a = r_acc; w_mm_b = r_acc;        end
            S_MUL:  begin w_mm_a = r_acc; w_mm_b = r_xm;         end
            S_FROM: begin w_mm_a = r_acc; w_mm_b = WIDTH'(1);    end
            default: begin w_mm_a = '0;   w_mm_b = '0;           end
        endcase
    end

    // Operand capture, exponent scanning and multiplier result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= '0;
            r_xm     <= '0;
            r_rr     <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_e      <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_x   <= in_x;
                r_e   <= in_e;
                r_m   <= in_m;
                r_rr  <= in_rr;
                r_acc <= in_r;
                r_cnt <= '0;
            end
            if ((r_state == S_SKIP && !r_e[EXP_WIDTH-1]) || r_state == S_NEXT) begin
                r_e   <= {r_e[EXP_WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                case (r_state)
                    S_TOM:   r_xm     <= mm_result;
                    S_FROM:  r_result <= mm_result;
                    default: r_acc    <= mm_result;
                endcase
            end
        end
    end

    assign result   = r_result;
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state != S_IDLE);
    assign mm_start = w_mm_start;
    assign mm_a     = w_mm_a;
    assign mm_b     = w_mm_b;
    assign mm_m     = r_m;

endmodule
`default_nettype wire
